// File: rtl/pll_lock_reset_seq.sv
// PLL power/lock sequencer: drives POWERDOWN, synchronises LOCK and holds the SDRAM controller in reset until lock is stable.
// Optional macro PLL_LOCK_GLITCH_FILTER_EN: lock loss in STABLE/RUN needs 4 consecutive low cycles of synced LOCK.
module pll_lock_reset_seq #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int PD_MIN_CYCLES       = 16,
    parameter int CNT_W               = 8
) (
    input  logic             HCLK,
    input  logic             HRESETN,
    input  logic             LOCK,
    input  logic             PD_REQ,
    output logic             POWERDOWN,
    output logic             SDR_RESETN,
    output logic             READY,
    output logic             PD_ACK,
    output logic             LOCK_TIMEOUT,
    output logic [CNT_W-1:0] LOCK_LOSS_CNT
);

    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W     = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int PD_W     = $clog2(PD_MIN_CYCLES + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [PD_W-1:0]     PD_LAST     = PD_W'(PD_MIN_CYCLES - 1);

    typedef enum logic [2:0] {
        PWRDN,
        WAIT_LOCK,
        STABLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic                lock_meta;
    logic                lock_s;
    logic                lock_lost;
    logic [STABLE_W-1:0] stable_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [PD_W-1:0]     pd_cnt;
    logic                stable_done;
    logic                timeout_hit;
    logic                pd_done;

    logic             powerdown_d;
    logic             sdr_resetn_d;
    logic             ready_d;
    logic             pd_ack_d;
    logic             lock_timeout_d;
    logic [CNT_W-1:0] loss_cnt_d;

    // LOCK is meaningless while the PLL is powered down, so the synchroniser is
    // flushed in PWRDN and every relock starts from a clean low.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (state == PWRDN) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
        end
    end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    logic [1:0] low_cnt;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            low_cnt <= 2'd0;
        end else if (lock_s) begin
            low_cnt <= 2'd0;
        end else if (low_cnt != 2'd3) begin
            low_cnt <= low_cnt + 2'd1;
        end
    end

    assign lock_lost = !lock_s && (low_cnt == 2'd3);
`else
    assign lock_lost = !lock_s;
`endif

    assign stable_done = (stable_cnt == STABLE_LAST);
    assign timeout_hit = (to_cnt == TO_LAST);
    assign pd_done     = (pd_cnt == PD_LAST);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state <= PWRDN;
        end else begin
            state <= state_next;
        end
    end

    // A power-down request always beats lock events, so a simultaneous lock
    // drop in RUN is never counted as a loss.
    always_comb begin
        state_next = state;
        case (state)
            PWRDN: begin
                if (pd_done && !PD_REQ) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (PD_REQ) begin
                    state_next = DRAIN;
                end else if (lock_s) begin
                    state_next = STABLE;
                end else if (timeout_hit) begin
                    state_next = PWRDN;
                end
            end
            STABLE: begin
                if (PD_REQ) begin
                    state_next = DRAIN;
                end else if (lock_lost) begin
                    state_next = WAIT_LOCK;
                end else if (stable_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (PD_REQ) begin
                    state_next = DRAIN;
                end else if (lock_lost) begin
                    state_next = WAIT_LOCK;
                end
            end
            DRAIN: begin
                state_next = PWRDN;
            end
            default: begin
                state_next = PWRDN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        powerdown_d    = (state_next != PWRDN);
        sdr_resetn_d   = (state_next == RUN);
        ready_d        = (state_next == RUN);
        pd_ack_d       = (state_next == PWRDN) && PD_REQ;
        lock_timeout_d = LOCK_TIMEOUT;
        loss_cnt_d     = LOCK_LOSS_CNT;
        if (state == WAIT_LOCK && state_next == PWRDN) begin
            lock_timeout_d = 1'b1;
        end
        if (state == RUN && state_next == WAIT_LOCK && LOCK_LOSS_CNT != '1) begin
            loss_cnt_d = LOCK_LOSS_CNT + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            POWERDOWN     <= 1'b0;
            SDR_RESETN    <= 1'b0;
            READY         <= 1'b0;
            PD_ACK        <= 1'b0;
            LOCK_TIMEOUT  <= 1'b0;
            LOCK_LOSS_CNT <= '0;
        end else begin
            POWERDOWN     <= powerdown_d;
            SDR_RESETN    <= sdr_resetn_d;
            READY         <= ready_d;
            PD_ACK        <= pd_ack_d;
            LOCK_TIMEOUT  <= lock_timeout_d;
            LOCK_LOSS_CNT <= loss_cnt_d;
        end
    end

    // Each counter only runs while its state persists and restarts from zero on every entry.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            stable_cnt <= '0;
            to_cnt     <= '0;
            pd_cnt     <= '0;
        end else begin
            if (state == STABLE && state_next == STABLE) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end

            if (state == WAIT_LOCK && state_next == WAIT_LOCK) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (state == PWRDN && state_next == PWRDN) begin
                if (!pd_done) begin
                    pd_cnt <= pd_cnt + 1'b1;
                end
            end else begin
                pd_cnt <= '0;
            end
        end
    end

endmodule
